piano_key_renderer: RTL



---
 rtl/piano_vga_pkg.sv | 44 ++++
 rtl/piano_key_hold.sv | 54 +++++
 rtl/piano_key_renderer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/piano_vga_pkg.sv
// Shared colours, note tables and pipeline record for the piano keyboard renderer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piano_vga_pkg;

  localparam int NUM_KEYS = 24;
  localparam int WIDX_W   = 4;   // white key index within the two octaves
  localparam int OFF_W    = 8;   // pixel offset inside one white key
  localparam int OCT_W    = 2;   // octave number

  // 4:4:4 colours packed as {R,G,B}
  localparam logic [11:0] C_OFF    = 12'h000;
  localparam logic [11:0] C_BG     = 12'h112;
  localparam logic [11:0] C_WHITE  = 12'hFFF;
  localparam logic [11:0] C_BLACK  = 12'h000;
  localparam logic [11:0] C_BORDER = 12'h444;
  localparam logic [11:0] C_LIT_W  = 12'h4AF;
  localparam logic [11:0] C_LIT_B  = 12'h26C;

  // Semitone of each white degree C D E F G A B
  localparam logic [6:0][3:0] NT = {4'd11, 4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0};
  // Bit d set when a black key sits right of white degree d (C, D, F, G, A)
  localparam logic [6:0] HAS_BLK = 7'b0111011;

  // Stage-1 pipeline record
  typedef struct packed {
    logic              de;
    logic              hs;
    logic              vs;
    logic              in_x;
    logic              in_y;
    logic              blk_y;
    logic [WIDX_W-1:0] widx;
    logic [2:0]        deg;
    logic [OCT_W-1:0]  oct;
    logic [OFF_W-1:0]  off;
  } s1_t;

  // Chromatic index of the white key at (octave, degree)
  function automatic logic [4:0] key_of(input logic [OCT_W-1:0] oct, input logic [2:0] deg);
    return ({3'd0, oct} * 5'd12) + {1'b0, NT[deg]};
  endfunction

endpackage

// File: rtl/piano_key_hold.sv
// Latches the key mask once per frame and keeps released keys lit for HOLD_FRAMES frames.
// Latency: lit changes one cycle after the VSYNC rising edge, otherwise static for the frame.
// Backpressure: none; free-running on every clock.
module piano_key_hold
  import piano_vga_pkg::*;
#(
  parameter int HOLD_FRAMES = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_vsync,
  input  logic [NUM_KEYS-1:0] i_key_down,
  output logic [NUM_KEYS-1:0] o_lit
);

  localparam logic [3:0] L_HOLD = 4'(HOLD_FRAMES);

  logic                     r_vs_d;
  logic [NUM_KEYS-1:0]      r_shadow;
  logic [NUM_KEYS-1:0][3:0] r_cnt;
  logic                     w_tick;

  assign w_tick = i_vsync & ~r_vs_d;

  // Frame tick: sample the mask; counters reload from the previous frame's mask
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vs_d   <= 1'b0;
      r_shadow <= '0;
      r_cnt    <= '0;
    end else begin
      r_vs_d <= i_vsync;
      if (w_tick) begin
        r_shadow <= i_key_down;
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (r_shadow[k]) begin
            r_cnt[k] <= L_HOLD;
          end else if (r_cnt[k] != 4'd0) begin
            r_cnt[k] <= r_cnt[k] - 4'd1;
          end
        end
      end
    end
  end

  // A key is lit while latched down or while its afterglow is running
  always_comb begin
    o_lit = r_shadow;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (r_cnt[k] != 4'd0) o_lit[k] = 1'b1;
    end
  end

endmodule

// File: rtl/piano_key_renderer.sv
// Draws a two-octave piano keyboard with lit keys over the VGA raster.
// Latency: 2 cycles from XPOS/YPOS/syncs to RGB/syncs, no bubbles.
// Backpressure: none; one pixel accepted and produced every clock.
module piano_key_renderer
  import piano_vga_pkg::*;
#(
  parameter int X0          = 80,
  parameter int WHITE_W     = 80,
  parameter int BLACK_W     = 48,
  parameter int N_WHITE     = 14,
  parameter int KB_Y0       = 624,
  parameter int KB_H        = 400,
  parameter int BLACK_H     = 240,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [10:0] XPOS,
  input  logic [10:0] YPOS,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  input  logic [23:0] KEY_DOWN,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic [3:0]  VGA_RED,
  output logic [3:0]  VGA_GREEN,
  output logic [3:0]  VGA_BLUE
);

  localparam logic [10:0]       L_X_FIRST  = 11'(X0 + 1);
  localparam logic [10:0]       L_Y_TOP    = 11'(KB_Y0);
  localparam logic [10:0]       L_Y_BOT    = 11'(KB_Y0 + KB_H);
  localparam logic [10:0]       L_Y_BLK    = 11'(KB_Y0 + BLACK_H);
  localparam logic [OFF_W-1:0]  L_OFF_LAST = OFF_W'(WHITE_W - 1);
  localparam logic [OFF_W-1:0]  L_BLK_R    = OFF_W'(WHITE_W - BLACK_W / 2);
  localparam logic [OFF_W-1:0]  L_BLK_L    = OFF_W'(BLACK_W / 2);
  localparam logic [WIDX_W-1:0] L_W_LAST   = WIDX_W'(N_WHITE - 1);

  s1_t                 r_s1;
  logic [11:0]         r_rgb;
  logic                r_hs;
  logic                r_vs;
  logic [NUM_KEYS-1:0] w_lit;
  logic [2:0]          w_prev_deg;
  logic [OCT_W-1:0]    w_prev_oct;
  logic                w_blk_r;
  logic                w_blk_l;
  logic [4:0]          w_bkey;
  logic [4:0]          w_wkey;
  logic [11:0]         w_rgb;

  piano_key_hold #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_hold (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_vsync    (VSYNC_IN),
    .i_key_down (KEY_DOWN),
    .o_lit      (w_lit)
  );

  // Stage 1: running white-key/offset counter (no divider) plus row windows
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1 <= '0;
    end else begin
      r_s1.de    <= (XPOS != '0) && (YPOS != '0);
      r_s1.hs    <= HSYNC_IN;
      r_s1.vs    <= VSYNC_IN;
      r_s1.in_y  <= (YPOS > L_Y_TOP) && (YPOS <= L_Y_BOT);
      r_s1.blk_y <= (YPOS > L_Y_TOP) && (YPOS <= L_Y_BLK);
      if (XPOS == '0) begin
        r_s1.in_x <= 1'b0;
      end else if (XPOS == L_X_FIRST) begin
        r_s1.in_x <= 1'b1;
        r_s1.widx <= '0;
        r_s1.deg  <= '0;
        r_s1.oct  <= '0;
        r_s1.off  <= '0;
      end else if (r_s1.in_x) begin
        if (r_s1.off == L_OFF_LAST) begin
          r_s1.off <= '0;
          if (r_s1.widx == L_W_LAST) begin
            r_s1.in_x <= 1'b0;
          end else begin
            r_s1.widx <= r_s1.widx + 1'b1;
            if (r_s1.deg == 3'd6) begin
              r_s1.deg <= '0;
              r_s1.oct <= r_s1.oct + 1'b1;
            end else begin
              r_s1.deg <= r_s1.deg + 3'd1;
            end
          end
        end else begin
          r_s1.off <= r_s1.off + 1'b1;
        end
      end
    end
  end

  // Stage 2 decode: black keys overlap the right edge of one white key and the left edge of the next
  always_comb begin
    w_prev_deg = (r_s1.deg == 3'd0) ? 3'd6 : r_s1.deg - 3'd1;
    w_prev_oct = (r_s1.deg == 3'd0) ? r_s1.oct - 1'b1 : r_s1.oct;
    w_blk_r    = r_s1.in_x && r_s1.blk_y && (r_s1.off >= L_BLK_R)
                 && HAS_BLK[r_s1.deg] && (r_s1.widx < L_W_LAST);
    w_blk_l    = r_s1.in_x && r_s1.blk_y && (r_s1.off < L_BLK_L)
                 && (r_s1.widx != '0) && HAS_BLK[w_prev_deg];
    w_wkey     = key_of(r_s1.oct, r_s1.deg);
    w_bkey     = w_blk_r ? (w_wkey + 5'd1) : (key_of(w_prev_oct, w_prev_deg) + 5'd1);
    w_rgb      = C_BG;
    if (!r_s1.de) begin
      w_rgb = C_OFF;
    end else if (w_blk_r || w_blk_l) begin
      w_rgb = w_lit[w_bkey] ? C_LIT_B : C_BLACK;
    end else if (r_s1.in_x && r_s1.in_y) begin
      if (r_s1.off == '0) begin
        w_rgb = C_BORDER;
      end else begin
        w_rgb = w_lit[w_wkey] ? C_LIT_W : C_WHITE;
      end
    end
  end

  // Stage 2 register: colour and syncs leave together
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rgb <= '0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= r_s1.hs;
      r_vs  <= r_s1.vs;
    end
  end

  assign VGA_HSYNC = r_hs;
  assign VGA_VSYNC = r_vs;
  assign VGA_RED   = r_rgb[11:8];
  assign VGA_GREEN = r_rgb[7:4];
  assign VGA_BLUE  = r_rgb[3:0];

endmodule
